// File: rtl/sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = a - b - bw_in, with borrow out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    assign d      = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial (LSB first) subtractor with valid/ready handshakes on both sides.
// Optional borrow/zero flag outputs are built when SUB_FLAGS_EN is defined.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SUB_FLAGS_EN
    ,
    output logic             borrow,
    output logic             zero
`endif
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bw_q, bw_d;
    logic               cell_d, cell_bw;

`ifdef SUB_FLAGS_EN
    logic               borrow_q, borrow_d;
    logic               zero_q, zero_d;
`endif

    fs_cell u_fs_cell (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .bw_in  (bw_q),
        .d      (cell_d),
        .bw_out (cell_bw)
    );

    // RUN spends WIDTH cycles on bits, then one finishing cycle when cnt hits WIDTH.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
`ifdef SUB_FLAGS_EN
        borrow_d = borrow_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    out_d   = res_q;
`ifdef SUB_FLAGS_EN
                    borrow_d = bw_q;
                    zero_d   = (res_q == '0);
`endif
                    state_d = DONE;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {cell_d, res_q[WIDTH-1:1]};
                    bw_d  = cell_bw;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
        end
    end

`ifdef SUB_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign borrow = borrow_q;
    assign zero   = zero_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus scoreboard queue,
// with hand-written sequences for backpressure, ignored inputs and mid-run reset.
module tb_serial_subtractor;

    localparam int W       = 16;
    localparam int LATENCY = W + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out;
    logic          out_valid;
    logic          out_ready;
`ifdef SUB_FLAGS_EN
    logic          borrow;
    logic          zero;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SUB_FLAGS_EN
        ,
        .borrow    (borrow),
        .zero      (zero)
`endif
    );

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] expOut;
        logic         expBorrow;
        logic         expZero;
        int           hold;
        bit           alsoValid;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         bor;
        logic         zer;
    } exp_t;

    vec_t  vecs[8];
    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    int    edgeCount = 0;
    int    acceptEdge = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Wait for in_ready, present operands for one accepting edge, record the expectation.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] eo, input logic eb, input logic ez);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acceptEdge = edgeCount;
        in_valid   = 1'b0;
        e.res = eo;
        e.bor = eb;
        e.zer = ez;
        sb.push_back(e);
    endtask

    // Wait for out_valid, check latency/value, hold under backpressure, then handshake.
    task automatic checkOutput(input int hold, input bit alsoValid);
        exp_t e;
        int   waited;
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        check("latency", edgeCount - acceptEdge, LATENCY);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("result", {16'b0, out}, {16'b0, e.res});
`ifdef SUB_FLAGS_EN
        check("borrow", {31'b0, borrow}, {31'b0, e.bor});
        check("zero", {31'b0, zero}, {31'b0, e.zer});
`endif
        check("in_ready_done", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", {16'b0, out}, {16'b0, e.res});
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (alsoValid) begin
            a        = 16'h0F0F;
            b        = 16'h0101;
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_hs", {31'b0, in_ready}, 32'd1);
        check("valid_drop", {31'b0, out_valid}, 32'd0);
        check("result_retained", {16'b0, out}, {16'b0, e.res});
    endtask

    task automatic expectNoValid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{16'h0001, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 0, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 5, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 2, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0, 1, 1'b0};

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out", {16'b0, out}, 32'd0);
`ifdef SUB_FLAGS_EN
        check("reset_borrow", {31'b0, borrow}, 32'd0);
        check("reset_zero", {31'b0, zero}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].av, vecs[i].bv, vecs[i].expOut, vecs[i].expBorrow, vecs[i].expZero);
            checkOutput(vecs[i].hold, vecs[i].alsoValid);
        end

        // Operands presented during RUN must be ignored.
        applyStimulus(16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a        = 16'h0000;
        b        = 16'h0000;
        in_valid = 1'b1;
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput(0, 1'b0);
        expectNoValid("no_second_op", 25);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_idle", {31'b0, in_ready}, 32'd1);
        check("midrun_reset_out", {16'b0, out}, 32'd0);
        check("midrun_reset_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expectNoValid("no_valid_after_reset", 30);
        applyStimulus(16'h0005, 16'h0002, 16'h0003, 1'b0, 1'b0);
        checkOutput(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
